// File: rtl/spi_flash_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : spi_flash_loader
// Description : Power-up SPI master that reads the Atom ROM image from an
//               external SPI flash (READ 0x03) and writes it byte by byte
//               into the external SRAM, holding the Atom off the SRAM bus
//               until the copy is complete.
//               Optional build macro: SPI_FLASH_WAKE_EN (send 0xAB release-
//               from-power-down frame and wait WAKE_WAIT cycles first).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_loader #(
    parameter logic [23:0] FLASH_ADDR      = 24'h030000,
    parameter logic [17:0] BOOT_START_ADDR = 18'h02900,
    parameter logic [17:0] BOOT_END_ADDR   = 18'h0FFFF,
    parameter int          CLK_DIV         = 2
`ifdef SPI_FLASH_WAKE_EN
   ,parameter int          WAKE_WAIT       = 200
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        booting,
    output logic        progress,
    output logic        SCK,
    output logic        SSEL,
    output logic        MOSI,
    input  logic        MISO,
    input  logic        atom_RAMCS_b,
    input  logic        atom_RAMOE_b,
    input  logic        atom_RAMWE_b,
    input  logic [17:0] atom_RAMA,
    input  logic [7:0]  atom_RAMDin,
    output logic        ext_RAMCS_b,
    output logic        ext_RAMOE_b,
    output logic        ext_RAMWE_b,
    output logic [17:0] ext_RAMA,
    output logic [7:0]  ext_RAMDin
);

    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_CMD      = 4'd3;
    localparam logic [3:0] S_ADDR2    = 4'd4;
    localparam logic [3:0] S_ADDR1    = 4'd5;
    localparam logic [3:0] S_ADDR0    = 4'd6;
    localparam logic [3:0] S_READ     = 4'd7;
    localparam logic [3:0] S_WR1      = 4'd8;
    localparam logic [3:0] S_WR2      = 4'd9;
    localparam logic [3:0] S_WR3      = 4'd10;
    localparam logic [3:0] S_WR4      = 4'd11;
    localparam logic [3:0] S_DONE     = 4'd12;
`ifdef SPI_FLASH_WAKE_EN
    localparam logic [3:0] S_WAKE     = 4'd1;
    localparam logic [3:0] S_WAKE_GAP = 4'd2;
    localparam int                GAP_W    = $clog2(WAKE_WAIT + 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(WAKE_WAIT - 1);
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    logic [3:0]       state_q, state_d;
    logic             sck_q, sck_d, ssel_q, ssel_d, mosi_q, mosi_d;
    logic             we_q, we_d, booting_q, booting_d, progress_q, progress_d;
    logic             lead_q, lead_d;
    logic [17:0]      a_q, a_d;
    logic [7:0]       din_q, din_d, tx_q, tx_d, rx_q, rx_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic             miso_s1_q, miso_s2_q;
    logic [7:0]       w_rx_next;
    logic             w_shifting;

    assign w_rx_next = {rx_q[6:0], miso_s2_q};

`ifdef SPI_FLASH_WAKE_EN
    assign w_shifting = (state_q == S_CMD) || (state_q == S_ADDR2) || (state_q == S_ADDR1) ||
                        (state_q == S_ADDR0) || (state_q == S_READ) || (state_q == S_WAKE);
`else
    assign w_shifting = (state_q == S_CMD) || (state_q == S_ADDR2) || (state_q == S_ADDR1) ||
                        (state_q == S_ADDR0) || (state_q == S_READ);
`endif

    // Sequencer and SPI bit engine: computes the next value of every register.
    always_comb begin
        state_d    = state_q;
        sck_d      = sck_q;
        ssel_d     = ssel_q;
        mosi_d     = mosi_q;
        we_d       = we_q;
        a_d        = a_q;
        din_d      = din_q;
        booting_d  = booting_q;
        progress_d = 1'b0;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        lead_d     = lead_q;
`ifdef SPI_FLASH_WAKE_EN
        gap_d      = gap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef SPI_FLASH_WAKE_EN
                    state_d = S_WAKE;
                    tx_d    = 8'hAB;
`else
                    state_d = S_CMD;
                    tx_d    = 8'h03;
`endif
                    ssel_d  = 1'b0;
                    lead_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = 3'd0;
                    sck_d   = 1'b0;
                end
            end
`ifdef SPI_FLASH_WAKE_EN
            S_WAKE_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = S_CMD;
                    ssel_d  = 1'b0;
                    lead_d  = 1'b1;
                    tx_d    = 8'h03;
                    gap_d   = '0;
                end
            end
`endif
            // Address and data already stable for a cycle; drop write strobe.
            S_WR1: begin
                we_d    = 1'b0;
                state_d = S_WR2;
            end
            S_WR2: state_d = S_WR3;
            S_WR3: begin
                we_d       = 1'b1;
                progress_d = 1'b1;
                state_d    = S_WR4;
            end
            // Address advances only after WE_b has been high for a cycle.
            S_WR4: begin
                if (a_q == BOOT_END_ADDR) begin
                    state_d   = S_DONE;
                    ssel_d    = 1'b1;
                    booting_d = 1'b0;
                end else begin
                    a_d     = a_q + 18'd1;
                    state_d = S_READ;
                end
            end
            S_DONE: ;
            default: begin
                if (!w_shifting) begin
                    state_d = S_IDLE;
                end else if (lead_q) begin
                    // One setup cycle after SSEL falls before bit 7 is driven.
                    lead_d = 1'b0;
                    mosi_d = tx_q[7];
                end else if (!sck_q) begin
                    if (div_q == DIV_LAST) begin
                        sck_d = 1'b1;
                        div_d = '0;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end else begin
                    // Sample on the first clk of the high phase so the
                    // synchroniser has caught up with the flash output.
                    if (div_q == '0) begin
                        rx_d = w_rx_next;
                    end
                    if (div_q == DIV_LAST) begin
                        sck_d = 1'b0;
                        div_d = '0;
                        if (bit_q == 3'd7) begin
                            bit_d = 3'd0;
                            case (state_q)
`ifdef SPI_FLASH_WAKE_EN
                                S_WAKE: begin
                                    state_d = S_WAKE_GAP;
                                    ssel_d  = 1'b1;
                                    mosi_d  = 1'b0;
                                    gap_d   = '0;
                                end
`endif
                                S_CMD: begin
                                    state_d = S_ADDR2;
                                    tx_d    = FLASH_ADDR[23:16];
                                    mosi_d  = FLASH_ADDR[23];
                                end
                                S_ADDR2: begin
                                    state_d = S_ADDR1;
                                    tx_d    = FLASH_ADDR[15:8];
                                    mosi_d  = FLASH_ADDR[15];
                                end
                                S_ADDR1: begin
                                    state_d = S_ADDR0;
                                    tx_d    = FLASH_ADDR[7:0];
                                    mosi_d  = FLASH_ADDR[7];
                                end
                                S_ADDR0: begin
                                    state_d = S_READ;
                                    tx_d    = 8'h00;
                                    mosi_d  = 1'b0;
                                end
                                default: begin
                                    state_d = S_WR1;
                                    din_d   = (div_q == '0) ? w_rx_next : rx_q;
                                end
                            endcase
                        end else begin
                            bit_d  = bit_q + 3'd1;
                            tx_d   = {tx_q[6:0], 1'b0};
                            mosi_d = tx_q[6];
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // State registers; reset returns the loader to its power-up condition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sck_q      <= 1'b0;
            ssel_q     <= 1'b1;
            mosi_q     <= 1'b0;
            we_q       <= 1'b1;
            a_q        <= BOOT_START_ADDR;
            din_q      <= 8'h00;
            booting_q  <= 1'b1;
            progress_q <= 1'b0;
            div_q      <= '0;
            bit_q      <= 3'd0;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            lead_q     <= 1'b0;
            miso_s1_q  <= 1'b0;
            miso_s2_q  <= 1'b0;
`ifdef SPI_FLASH_WAKE_EN
            gap_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sck_q      <= sck_d;
            ssel_q     <= ssel_d;
            mosi_q     <= mosi_d;
            we_q       <= we_d;
            a_q        <= a_d;
            din_q      <= din_d;
            booting_q  <= booting_d;
            progress_q <= progress_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            lead_q     <= lead_d;
            miso_s1_q  <= MISO;
            miso_s2_q  <= miso_s1_q;
`ifdef SPI_FLASH_WAKE_EN
            gap_q      <= gap_d;
`endif
        end
    end

    assign booting  = booting_q;
    assign progress = progress_q;
    assign SCK      = sck_q;
    assign SSEL     = ssel_q;
    assign MOSI     = mosi_q;

    // SRAM bus: loader owns it while booting, otherwise Atom passes through.
    assign ext_RAMCS_b = booting_q ? 1'b0  : atom_RAMCS_b;
    assign ext_RAMOE_b = booting_q ? 1'b1  : atom_RAMOE_b;
    assign ext_RAMWE_b = booting_q ? we_q  : atom_RAMWE_b;
    assign ext_RAMA    = booting_q ? a_q   : atom_RAMA;
    assign ext_RAMDin  = booting_q ? din_q : atom_RAMDin;

endmodule
`default_nettype wire
